// File: rtl/store_line_merge_pkg.sv
// Shared types for the store line merge buffer.
// Line, mask, tag and word-index widths plus the buffer FSM states.
package store_line_merge_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_line_mask;
  typedef logic [11:0]  lc3b_line_tag;
  typedef logic [2:0]   lc3b_word_idx;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_VALID,
    ST_DRAIN
  } slm_state_e;

  localparam lc3b_line_mask FULL_MASK = 16'hFFFF;

  function automatic lc3b_line expand_mask(
    input lc3b_line_mask m
  );
    lc3b_line r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/store_line_merge_insert_16.sv
// Places a 16-bit masked store into its word slot of a 128-bit line.
// Inverse of the line-to-word extractor; bytes outside the store are zero.
module store_line_merge_insert_16
  import store_line_merge_pkg::*;
(
  input  lc3b_word      data_16,
  input  lc3b_word_idx  word_idx,
  input  lc3b_mem_wmask wmask,
  output lc3b_line      placed,
  output lc3b_line_mask sel_mask
);

  always_comb begin
    placed   = '0;
    sel_mask = '0;
    placed[16*word_idx +: 16] =
      data_16 & {{8{wmask[1]}}, {8{wmask[0]}}};
    sel_mask[2*word_idx +: 2] = wmask;
  end

endmodule

// File: rtl/store_line_merge.sv
// One-entry store coalescing buffer: merges word stores into a line
// and drains it downstream as a single byte-masked line write.
module store_line_merge
  import store_line_merge_pkg::*;
#(
  parameter logic AUTO_DRAIN_FULL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_write,
  input  logic [15:0]  cpu_addr,
  input  logic [15:0]  cpu_wdata,
  input  logic [1:0]   cpu_wmask,
  output logic         cpu_resp,
  input  logic         flush,
  output logic         idle,
  input  logic [15:0]  chk_addr,
  output logic         chk_hit,
  output logic         mem_write,
  output logic [15:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic [15:0]  mem_byte_mask,
  input  logic         mem_resp
);

  slm_state_e    state_q, state_d;
  lc3b_line_tag  tag_q, tag_d;
  lc3b_line      data_q, data_d;
  lc3b_line_mask mask_q, mask_d;

  lc3b_line      placed;
  lc3b_line_mask sel_mask;
  lc3b_line      merged_data;
  lc3b_line_mask merged_mask;
  logic          tag_hit;
  logic          unused_ok;

  store_line_merge_insert_16 u_insert (
    .data_16  (cpu_wdata),
    .word_idx (cpu_addr[3:1]),
    .wmask    (cpu_wmask),
    .placed   (placed),
    .sel_mask (sel_mask)
  );

  assign tag_hit     = cpu_addr[15:4] == tag_q;
  assign merged_data =
    (data_q & ~expand_mask(sel_mask)) | placed;
  assign merged_mask = mask_q | sel_mask;
  assign unused_ok   = ^{cpu_addr[0], chk_addr[3:0]};

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    data_d   = data_q;
    mask_d   = mask_q;
    cpu_resp = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (cpu_write) begin
          cpu_resp = 1'b1;
          if (cpu_wmask != 2'b00) begin
            // First store of a line starts from a zeroed line
            tag_d   = cpu_addr[15:4];
            data_d  = placed;
            mask_d  = sel_mask;
            state_d = (AUTO_DRAIN_FULL && sel_mask == FULL_MASK)
                      ? ST_DRAIN : ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (cpu_write && tag_hit) begin
          cpu_resp = 1'b1;
          data_d   = merged_data;
          mask_d   = merged_mask;
          if (AUTO_DRAIN_FULL && merged_mask == FULL_MASK) begin
            state_d = ST_DRAIN;
          end
        end else if (cpu_write || flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_resp) begin
          mask_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      tag_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign idle          = state_q == ST_EMPTY;
  assign chk_hit       = (state_q != ST_EMPTY) &&
                         (chk_addr[15:4] == tag_q);
  assign mem_write     = state_q == ST_DRAIN;
  assign mem_addr      = {tag_q, 4'b0000};
  assign mem_wdata     = data_q;
  assign mem_byte_mask = mask_q;

endmodule

// File: tb/tb_store_line_merge.sv
// Bench for store_line_merge: byte-array reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_store_line_merge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_write = 1'b0;
  logic [15:0]  cpu_addr = '0;
  logic [15:0]  cpu_wdata = '0;
  logic [1:0]   cpu_wmask = '0;
  logic         cpu_resp;
  logic         flush = 1'b0;
  logic         idle;
  logic [15:0]  chk_addr = '0;
  logic         chk_hit;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_byte_mask;
  logic         mem_resp = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 0;

  store_line_merge dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_write     (cpu_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_wmask     (cpu_wmask),
    .cpu_resp      (cpu_resp),
    .flush         (flush),
    .idle          (idle),
    .chk_addr      (chk_addr),
    .chk_hit       (chk_hit),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_byte_mask (mem_byte_mask),
    .mem_resp      (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a line is a set of 16 bytes with valid flags
  bit          m_has = 0;
  bit          m_drain = 0;
  logic [11:0] m_tag = '0;
  logic [7:0]  m_b [16];
  bit          m_v [16];

  function automatic bit exp_resp();
    return cpu_write && !m_drain &&
           (!m_has || cpu_addr[15:4] == m_tag);
  endfunction

  function automatic logic [127:0] exp_line();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_b[i];
    return r;
  endfunction

  function automatic logic [15:0] exp_mask();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_v[i];
    return r;
  endfunction

  task automatic model_clear();
    m_has = 0;
    m_drain = 0;
    for (int i = 0; i < 16; i++) begin
      m_b[i] = 8'h00;
      m_v[i] = 0;
    end
  endtask

  initial model_clear();

  always @(posedge clk) begin
    if (reset) begin
      model_clear();
      m_tag = '0;
    end else if (m_drain) begin
      if (mem_resp) begin
        m_has = 0;
        m_drain = 0;
      end
    end else if (exp_resp()) begin
      if (cpu_wmask != 2'b00) begin
        int w;
        bit full;
        if (!m_has) begin
          model_clear();
          m_has = 1;
          m_tag = cpu_addr[15:4];
        end
        w = int'(cpu_addr[3:1]);
        if (cpu_wmask[0]) begin
          m_b[2*w] = cpu_wdata[7:0];
          m_v[2*w] = 1;
        end
        if (cpu_wmask[1]) begin
          m_b[2*w+1] = cpu_wdata[15:8];
          m_v[2*w+1] = 1;
        end
        full = 1;
        for (int i = 0; i < 16; i++) if (!m_v[i]) full = 0;
        if (full) m_drain = 1;
      end
    end else if (m_has && (cpu_write || flush)) begin
      m_drain = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cpu_resp", cpu_resp, exp_resp());
      chk("idle", idle, !m_has);
      chk("mem_write", mem_write, m_drain);
      chk("chk_hit", chk_hit,
          m_has && chk_addr[15:4] == m_tag);
      if (m_drain) begin
        chk("mem_addr", mem_addr, {m_tag, 4'h0});
        chk("mem_wdata", mem_wdata, exp_line());
        chk("mem_byte_mask", mem_byte_mask, exp_mask());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a,
                       input logic [15:0] d,
                       input logic [1:0] m);
    bit got;
    got = 0;
    cpu_write = 1;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_wmask = m;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = cpu_resp;
      cyc();
    end
    cpu_write = 0;
    if (!got) chk("store_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    flush = 1;
    while (!mem_write && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) chk("drain_timeout", 0, 1);
  endtask

  task automatic finish_drain();
    mem_resp = 1;
    cyc();
    mem_resp = 0;
    flush = 0;
  endtask

  logic [11:0] tags [4];
  bit last_resp;

  initial begin
    tags[0] = 12'h010;
    tags[1] = 12'h011;
    tags[2] = 12'hABC;
    tags[3] = 12'hFFF;
    cyc();
    cyc();
    cmp_en = 1;
    reset = 0;

    // Reset state and first store
    #1;
    chk("t1_idle", idle, 1);
    chk("t1_mem_write", mem_write, 0);
    chk("t1_chk_hit", chk_hit, 0);
    cpu_write = 1;
    cpu_addr = 16'h0000;
    cpu_wdata = 16'h1234;
    cpu_wmask = 2'b11;
    #1;
    chk("t1_resp", cpu_resp, 1);
    cyc();
    cpu_write = 0;
    #1;
    chk("t1_idle_after", idle, 0);
    wait_drain();
    finish_drain();

    // Coalesce then flush
    store(16'h1002, 16'hBEEF, 2'b11);
    store(16'h1004, 16'h0012, 2'b01);
    wait_drain();
    chk("t2_addr", mem_addr, 16'h1000);
    chk("t2_mask", mem_byte_mask, 16'h001C);
    chk("t2_data", mem_wdata,
        128'h0000_0000_0000_0000_0000_0012_BEEF_0000);
    finish_drain();
    chk("t2_idle", idle, 1);

    // Conflicting store waits for the drain
    store(16'h1000, 16'h5555, 2'b11);
    cpu_write = 1;
    cpu_addr = 16'h2000;
    cpu_wdata = 16'hAAAA;
    cpu_wmask = 2'b11;
    #1;
    chk("t3_resp_conflict", cpu_resp, 0);
    cyc();
    chk("t3_mem_write", mem_write, 1);
    chk("t3_mem_addr", mem_addr, 16'h1000);
    cyc();
    cyc();
    mem_resp = 1;
    #1;
    chk("t3_resp_in_memresp", cpu_resp, 0);
    cyc();
    mem_resp = 0;
    chk("t3_resp_after", cpu_resp, 1);
    cyc();
    cpu_write = 0;
    chk_addr = 16'h2006;
    #1;
    chk("t3_hit_new", chk_hit, 1);
    chk_addr = 16'h1000;
    #1;
    chk("t3_hit_old", chk_hit, 0);
    wait_drain();
    finish_drain();

    // Full line drains without flush
    for (int w = 0; w < 8; w++)
      store(16'h3000 + 16'(2*w), 16'($urandom), 2'b11);
    chk("t4_mem_write", mem_write, 1);
    chk("t4_mask", mem_byte_mask, 16'hFFFF);
    finish_drain();

    // Later byte overwrites earlier
    store(16'h4000, 16'h1111, 2'b11);
    store(16'h4001, 16'h22AA, 2'b01);
    wait_drain();
    chk("t5_word0", mem_wdata[15:0], 16'h11AA);
    chk("t5_mask", mem_byte_mask, 16'h0003);
    finish_drain();

    // Reset while draining; late mem_resp ignored
    store(16'h5000, 16'h7777, 2'b10);
    wait_drain();
    reset = 1;
    flush = 0;
    cyc();
    reset = 0;
    chk("t6_mem_write", mem_write, 0);
    chk("t6_idle", idle, 1);
    mem_resp = 1;
    cyc();
    mem_resp = 0;
    chk("t6_idle_late", idle, 1);
    chk("t6_mem_write_late", mem_write, 0);

    // Random traffic under protocol rules
    last_resp = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(cpu_write && !last_resp)) begin
        cpu_write = $urandom_range(0, 1) == 1;
        cpu_addr = {tags[$urandom_range(0, 3)],
                    4'($urandom)};
        cpu_wdata = 16'($urandom);
        cpu_wmask = 2'($urandom);
      end
      if (!(flush && !idle))
        flush = $urandom_range(0, 7) == 0;
      mem_resp = $urandom_range(0, 2) == 0;
      chk_addr = {tags[$urandom_range(0, 3)], 4'($urandom)};
      reset = $urandom_range(0, 299) == 0;
      #1;
      last_resp = cpu_resp;
      cyc();
    end
    reset = 0;
    cpu_write = 0;
    flush = 0;
    mem_resp = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
